// File: rtl/lc3b_pipe_pkg.sv
// Shared LC-3b pipeline definitions: control-store field positions, opcodes and IR field helpers.
package lc3b_pipe_pkg;

  localparam int SR1_NEEDED = 22;
  localparam int SR2_NEEDED = 21;
  localparam int DR_MUX     = 20;
  localparam int BR_OP      = 10;
  localparam int BR_STALL   = 7;
  localparam int LD_REG     = 1;
  localparam int LD_CC      = 0;

  // Only the low AGEX_CS_W bits travel past decode; the top fields are decode-only.
  localparam int AGEX_CS_W  = 20;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDW  = 4'h6;
  localparam logic [3:0] OP_STW  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SHF  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  // Stores read their data register from ir[11:9]; ir[13] separates them from ALU ops.
  function automatic logic [2:0] sr2_field(input logic [15:0] ir);
    return ir[13] ? ir[11:9] : ir[2:0];
  endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Bank of N saturating up/down in-flight write counters with zero/one/max flags, updated every edge.
// Simultaneous inc and dec leave an entry unchanged; a retire against an empty entry is flagged in simulation.
module sb_counter_bank #(
  parameter int N     = 9,
  parameter int CNT_W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] inc,
  input  logic [N-1:0] dec,
  output logic [N-1:0] is_zero,
  output logic [N-1:0] is_one,
  output logic [N-1:0] is_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (inc[i] && !dec[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  always_comb begin
    is_zero = '0;
    is_one  = '0;
    is_max  = '0;
    for (int i = 0; i < N; i++) begin
      is_zero[i] = (cnt[i] == '0);
      is_one[i]  = (cnt[i] == CNT_ONE);
      is_max[i]  = (cnt[i] == CNT_MAX);
    end
  end

  // A writeback with nothing outstanding means the producer side lost track of its issues.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset_n) assert (!(dec[i] && is_zero[i]))
        else $error("sb_counter_bank: retire on empty entry %0d", i);
    end
  end

endmodule

// File: rtl/decode_sb_stage.sv
// LC-3b decode: DE latch, regfile, counter scoreboards, registered AGEX latch; issue lands in AGEX 1 cycle after DE.
// Hazards or mem_stall hold DE (de_stall); mem_stall also freezes AGEX. DECODE_BYPASS_EN forwards same-cycle writeback.
module decode_sb_stage
  import lc3b_pipe_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  parameter  int CS_W     = 23,
  parameter  int CNT_W    = 2,
  localparam int RID_W    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fe_v,
  input  logic [DATA_W-1:0]    fe_ir,
  input  logic [DATA_W-1:0]    fe_npc,
  input  logic                 flush,
  input  logic                 mem_stall,
  output logic [5:0]           cs_addr,
  input  logic [CS_W-1:0]      cs_bits,
  input  logic                 wb_v,
  input  logic                 wb_ld_reg,
  input  logic                 wb_ld_cc,
  input  logic [RID_W-1:0]     wb_drid,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 de_stall,
  output logic                 v_de_br_stall,
  output logic                 agex_v,
  output logic [DATA_W-1:0]    agex_npc,
  output logic [DATA_W-1:0]    agex_ir,
  output logic [DATA_W-1:0]    agex_sr1,
  output logic [DATA_W-1:0]    agex_sr2,
  output logic [RID_W-1:0]     agex_drid,
  output logic [AGEX_CS_W-1:0] agex_cs
);

  localparam int CC = NUM_REGS;  // last scoreboard entry tracks the condition codes

  logic              de_v;
  logic [DATA_W-1:0] de_ir;
  logic [DATA_W-1:0] de_npc;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic [RID_W-1:0]  sr1, sr2, dr;
  logic [NUM_REGS:0] sb_inc, sb_dec, sb_zero, sb_one, sb_max;
  logic              fwd1, fwd2, fwd_cc;
  logic              busy1, busy2, busy_cc;
  logic              dep_stall, issue;
  logic [DATA_W-1:0] sr1_val, sr2_val;

  assign cs_addr = {de_ir[15:11], de_ir[5]};
  assign sr1     = RID_W'(de_ir[8:6]);
  assign sr2     = RID_W'(sr2_field(de_ir));
  assign dr      = cs_bits[DR_MUX] ? RID_W'(NUM_REGS - 1) : RID_W'(de_ir[11:9]);

  always_comb begin
`ifdef DECODE_BYPASS_EN
    // A last outstanding write retiring this cycle can be consumed straight off the writeback bus.
    fwd1   = wb_v & wb_ld_reg & (wb_drid == sr1) & sb_one[sr1];
    fwd2   = wb_v & wb_ld_reg & (wb_drid == sr2) & sb_one[sr2];
    fwd_cc = wb_v & wb_ld_cc & sb_one[CC];
`else
    fwd1   = 1'b0;
    fwd2   = 1'b0;
    fwd_cc = 1'b0;
`endif
    busy1   = ~sb_zero[sr1] & ~fwd1;
    busy2   = ~sb_zero[sr2] & ~fwd2;
    busy_cc = ~sb_zero[CC] & ~fwd_cc;
    sr1_val = fwd1 ? wb_data : rf[sr1];
    sr2_val = fwd2 ? wb_data : rf[sr2];
  end

  assign dep_stall = de_v & ((cs_bits[SR1_NEEDED] & busy1)
                           | (cs_bits[SR2_NEEDED] & busy2)
                           | (cs_bits[BR_OP] & busy_cc)
                           | (cs_bits[LD_REG] & sb_max[dr])
                           | (cs_bits[LD_CC] & sb_max[CC]));
  assign issue         = de_v & ~dep_stall & ~mem_stall & ~flush;
  assign de_stall      = de_v & (dep_stall | mem_stall);
  assign v_de_br_stall = de_v & cs_bits[BR_STALL];

  always_comb begin
    sb_inc = '0;
    sb_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_inc[r] = issue & cs_bits[LD_REG] & (dr == RID_W'(r));
      sb_dec[r] = wb_v & wb_ld_reg & (wb_drid == RID_W'(r));
    end
    sb_inc[CC] = issue & cs_bits[LD_CC];
    sb_dec[CC] = wb_v & wb_ld_cc;
  end

  sb_counter_bank #(
    .N     (NUM_REGS + 1),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sb_inc),
    .dec     (sb_dec),
    .is_zero (sb_zero),
    .is_one  (sb_one),
    .is_max  (sb_max)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else if (wb_v && wb_ld_reg) begin
      rf[wb_drid] <= wb_data;
    end
  end

  // Flush only squashes DE; nothing younger has reached the scoreboard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_v   <= 1'b0;
      de_ir  <= '0;
      de_npc <= '0;
    end else if (flush) begin
      de_v   <= 1'b0;
    end else if (!de_stall) begin
      de_v   <= fe_v;
      de_ir  <= fe_ir;
      de_npc <= fe_npc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      agex_v    <= 1'b0;
      agex_npc  <= '0;
      agex_ir   <= '0;
      agex_sr1  <= '0;
      agex_sr2  <= '0;
      agex_drid <= '0;
      agex_cs   <= '0;
    end else if (!mem_stall) begin
      agex_v    <= issue;
      agex_npc  <= de_npc;
      agex_ir   <= de_ir;
      agex_sr1  <= sr1_val;
      agex_sr2  <= sr2_val;
      agex_drid <= dr;
      agex_cs   <= cs_bits[AGEX_CS_W-1:0];
    end
  end

endmodule

// File: tb/tb_decode_sb_stage.sv
// Random and directed checks of decode_sb_stage against a queue-based model of outstanding writes.
module tb_decode_sb_stage;
  import lc3b_pipe_pkg::*;

  localparam int CS_W    = 23;
  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fe_v, flush, mem_stall;
  logic [15:0] fe_ir, fe_npc;
  logic [5:0]  cs_addr;
  logic [CS_W-1:0] cs_bits;
  logic        wb_v, wb_ld_reg, wb_ld_cc;
  logic [2:0]  wb_drid;
  logic [15:0] wb_data;
  logic        de_stall, v_de_br_stall, agex_v;
  logic [15:0] agex_npc, agex_ir, agex_sr1, agex_sr2;
  logic [2:0]  agex_drid;
  logic [19:0] agex_cs;

  always #5 clk = ~clk;

  decode_sb_stage dut (
    .clk(clk), .reset_n(reset_n), .fe_v(fe_v), .fe_ir(fe_ir), .fe_npc(fe_npc),
    .flush(flush), .mem_stall(mem_stall), .cs_addr(cs_addr), .cs_bits(cs_bits),
    .wb_v(wb_v), .wb_ld_reg(wb_ld_reg), .wb_ld_cc(wb_ld_cc), .wb_drid(wb_drid),
    .wb_data(wb_data), .de_stall(de_stall), .v_de_br_stall(v_de_br_stall),
    .agex_v(agex_v), .agex_npc(agex_npc), .agex_ir(agex_ir), .agex_sr1(agex_sr1),
    .agex_sr2(agex_sr2), .agex_drid(agex_drid), .agex_cs(agex_cs)
  );

  // Small external control store: decode-relevant fields per opcode, opcode echoed in the AGEX bits.
  function automatic logic [CS_W-1:0] cs_rom(input logic [5:0] a);
    logic [CS_W-1:0] c;
    c = '0;
    c[17:14] = a[5:2];
    c[13]    = a[0];
    case (a[5:2])
      OP_ADD, OP_AND, OP_XOR: begin
        c[SR1_NEEDED] = 1'b1; c[SR2_NEEDED] = ~a[0]; c[LD_REG] = 1'b1; c[LD_CC] = 1'b1;
      end
      OP_LDW:  begin c[SR1_NEEDED] = 1'b1; c[LD_REG] = 1'b1; c[LD_CC] = 1'b1; end
      OP_STW:  begin c[SR1_NEEDED] = 1'b1; c[SR2_NEEDED] = 1'b1; end
      OP_BR:   begin c[BR_OP] = 1'b1; c[BR_STALL] = 1'b1; end
      OP_JSR:  begin c[SR1_NEEDED] = 1'b1; c[DR_MUX] = 1'b1; c[LD_REG] = 1'b1; c[BR_STALL] = 1'b1; end
      OP_JMP:  begin c[SR1_NEEDED] = 1'b1; c[BR_STALL] = 1'b1; end
      OP_LEA:  c[LD_REG] = 1'b1;
      OP_TRAP: begin c[DR_MUX] = 1'b1; c[LD_REG] = 1'b1; c[BR_STALL] = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  assign cs_bits = cs_rom(cs_addr);

  typedef struct packed {
    logic       ld_reg;
    logic       ld_cc;
    logic [2:0] dr;
  } op_t;

  op_t         inflight[$];
  logic [15:0] prog[$];
  logic [15:0] m_rf [8];
  logic        m_de_v, m_agex_v;
  logic [15:0] m_de_ir, m_de_npc, m_agex_npc, m_agex_ir, m_agex_sr1, m_agex_sr2;
  logic [2:0]  m_agex_drid;
  logic [19:0] m_agex_cs;
  int fe_pct, wb_pct, ms_pct, fl_pct;
  int n_vec = 0;
  int n_err = 0;

  function automatic int pending(input logic [2:0] r);
    int n = 0;
    foreach (inflight[i]) if (inflight[i].ld_reg && inflight[i].dr == r) n++;
    return n;
  endfunction

  function automatic int cc_pending();
    int n = 0;
    foreach (inflight[i]) if (inflight[i].ld_cc) n++;
    return n;
  endfunction

  function automatic logic [15:0] add_ir(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    return {OP_ADD, d, s1, 3'b000, s2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_agex();
    chk("agex_v",    32'(agex_v),    32'(m_agex_v));
    chk("agex_npc",  32'(agex_npc),  32'(m_agex_npc));
    chk("agex_ir",   32'(agex_ir),   32'(m_agex_ir));
    chk("agex_sr1",  32'(agex_sr1),  32'(m_agex_sr1));
    chk("agex_sr2",  32'(agex_sr2),  32'(m_agex_sr2));
    chk("agex_drid", 32'(agex_drid), 32'(m_agex_drid));
    chk("agex_cs",   32'(agex_cs),   32'(m_agex_cs));
  endtask

  // Asynchronous reset asserted away from any clock edge; everything observable must read zero.
  task automatic do_reset();
    reset_n = 1'b0;
    fe_v = 1'b0; flush = 1'b0; mem_stall = 1'b0; wb_v = 1'b0;
    #3;
    inflight.delete();
    for (int r = 0; r < 8; r++) m_rf[r] = '0;
    m_de_v = 1'b0; m_de_ir = '0; m_de_npc = '0;
    m_agex_v = 1'b0; m_agex_npc = '0; m_agex_ir = '0; m_agex_sr1 = '0;
    m_agex_sr2 = '0; m_agex_drid = '0; m_agex_cs = '0;
    chk("rst_de_stall", 32'(de_stall), 32'd0);
    chk("rst_br_stall", 32'(v_de_br_stall), 32'd0);
    chk("rst_cs_addr", 32'(cs_addr), 32'd0);
    chk_agex();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic step();
    logic [CS_W-1:0] cs;
    logic [2:0] s1, s2, d;
    logic fw1, fw2, fwc, dep, iss, xstall, from_prog, wb_go;
    op_t w;
    flush     = ($urandom_range(99) < fl_pct);
    mem_stall = ($urandom_range(99) < ms_pct);
    from_prog = (prog.size() != 0);
    fe_v      = from_prog || ($urandom_range(99) < fe_pct);
    fe_ir     = from_prog ? prog[0] : 16'($urandom);
    fe_npc    = 16'($urandom);
    wb_go     = (inflight.size() != 0) && ($urandom_range(99) < wb_pct);
    w         = wb_go ? inflight[0] : op_t'(5'($urandom));
    wb_v      = wb_go;
    wb_ld_reg = w.ld_reg;
    wb_ld_cc  = w.ld_cc;
    wb_drid   = w.dr;
    wb_data   = 16'($urandom);
    #1;
    cs  = cs_rom({m_de_ir[15:11], m_de_ir[5]});
    s1  = m_de_ir[8:6];
    s2  = m_de_ir[13] ? m_de_ir[11:9] : m_de_ir[2:0];
    d   = cs[DR_MUX] ? 3'd7 : m_de_ir[11:9];
    fw1 = 1'b0; fw2 = 1'b0; fwc = 1'b0;
`ifdef DECODE_BYPASS_EN
    fw1 = wb_go && w.ld_reg && w.dr == s1 && pending(s1) == 1;
    fw2 = wb_go && w.ld_reg && w.dr == s2 && pending(s2) == 1;
    fwc = wb_go && w.ld_cc && cc_pending() == 1;
`endif
    dep = m_de_v && ((cs[SR1_NEEDED] && pending(s1) != 0 && !fw1)
                  || (cs[SR2_NEEDED] && pending(s2) != 0 && !fw2)
                  || (cs[BR_OP] && cc_pending() != 0 && !fwc)
                  || (cs[LD_REG] && pending(d) == CNT_MAX)
                  || (cs[LD_CC] && cc_pending() == CNT_MAX));
    iss    = m_de_v && !dep && !mem_stall && !flush;
    xstall = m_de_v && (dep || mem_stall);
    chk("de_stall", 32'(de_stall), 32'(xstall));
    chk("v_de_br_stall", 32'(v_de_br_stall), 32'(m_de_v && cs[BR_STALL]));
    chk("cs_addr", 32'(cs_addr), 32'({m_de_ir[15:11], m_de_ir[5]}));
    if (!mem_stall) begin
      m_agex_v = iss; m_agex_npc = m_de_npc; m_agex_ir = m_de_ir;
      m_agex_sr1 = fw1 ? wb_data : m_rf[s1];
      m_agex_sr2 = fw2 ? wb_data : m_rf[s2];
      m_agex_drid = d; m_agex_cs = cs[19:0];
    end
    if (wb_go) begin
      if (w.ld_reg) m_rf[w.dr] = wb_data;
      void'(inflight.pop_front());
    end
    if (iss && (cs[LD_REG] || cs[LD_CC])) inflight.push_back({cs[LD_REG], cs[LD_CC], d});
    if (flush) m_de_v = 1'b0;
    else if (!xstall) begin
      m_de_v = fe_v; m_de_ir = fe_ir; m_de_npc = fe_npc;
      if (from_prog) void'(prog.pop_front());
    end
    @(posedge clk);
    #1;
    chk_agex();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int fe, input int wb, input int ms, input int fl);
    fe_pct = fe; wb_pct = wb; ms_pct = ms; fl_pct = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    fe_ir = '0; fe_npc = '0; wb_ld_reg = 1'b0; wb_ld_cc = 1'b0; wb_drid = '0; wb_data = '0;
    do_reset();

    // Populate the register file with random traffic, then drain all outstanding writes.
    knobs(70, 50, 10, 5);  run(300);
    knobs(0, 100, 0, 0);   run(40);

    // RAW on R1: the consumer waits for R1's writeback.
    prog.push_back(add_ir(3'd1, 3'd2, 3'd3));
    prog.push_back(add_ir(3'd4, 3'd1, 3'd1));
    knobs(0, 0, 0, 0);     run(4);
    knobs(0, 100, 0, 0);   run(5);

    // Four writes to R5: the fourth waits for a counter slot.
    for (int i = 0; i < 4; i++) prog.push_back(add_ir(3'd5, 3'd0, 3'd0));
    knobs(0, 0, 0, 0);     run(6);
    knobs(0, 100, 0, 0);   run(8);

    // CC producer followed by a branch.
    prog.push_back(add_ir(3'd1, 3'd2, 3'd3));
    prog.push_back(16'h0E05);
    knobs(0, 0, 0, 0);     run(4);
    knobs(0, 100, 0, 0);   run(5);

    // Issue to R2 while a single R2 write retires in the same cycle.
    prog.push_back(add_ir(3'd2, 3'd0, 3'd0));
    prog.push_back(add_ir(3'd2, 3'd0, 3'd0));
    prog.push_back(add_ir(3'd6, 3'd2, 3'd0));
    knobs(0, 100, 0, 0);   run(8);

    // Downstream stall with DE valid holds everything for three cycles.
    prog.push_back(add_ir(3'd6, 3'd0, 3'd1));
    knobs(0, 0, 0, 0);     run(1);
    knobs(0, 0, 100, 0);   run(3);
    knobs(0, 100, 0, 0);   run(4);

    // Stalled consumer squashed by flush, then reset mid-stream with writes in flight.
    prog.push_back(add_ir(3'd2, 3'd3, 3'd4));
    prog.push_back(add_ir(3'd3, 3'd2, 3'd2));
    knobs(0, 0, 0, 0);     run(3);
    knobs(0, 0, 0, 100);   run(1);
    knobs(0, 0, 0, 0);     run(2);
    prog.delete();
    do_reset();

    // Long random soak with periodic resets.
    for (int k = 0; k < 3; k++) begin
      knobs(80, 40 + 20 * k, 15, 4);
      run(500);
      do_reset();
    end
    knobs(90, 60, 5, 2);   run(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
